// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  // ALU operation codes seen by the datapath ALU
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the FSM's operation class plus funct3/funct7b5 onto the ALU control code.
// Latency: combinational.
// Backpressure: none; flags unsupported funct3 encodings via bad_funct.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl,
  output logic       bad_funct
);

  // Fixed ADD/SUB for address and compare steps, funct3 decode for R/I execution
  always_comb begin
    alu_ctrl  = ALU_ADD;
    bad_funct = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          // funct7b5 is an immediate bit for addi, so only R-type honours it
          3'b000:  alu_ctrl = (alu_op == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: bad_funct = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I subset core: sequences PC/memory/IR/regfile/ALU.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles; illegal op 2 cycles, bad funct3 3 cycles.
// Backpressure: none; reset aborts any instruction with all write enables held low.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [3:0] alu_ctrl,
  output logic       retire,
  output logic       illegal
);

  state_t     state, state_next, cur;
  state_t     fault_next;
  logic [1:0] alu_op;
  logic       bad_funct;
  logic       pc_update, branch, mem_write_s, ir_write_s, reg_write_s;
  logic       retire_s, illegal_s;

  // While reset is high the outputs follow the FETCH decode regardless of the stored state
  assign cur        = reset ? FETCH : state;
  assign fault_next = ILLEGAL_HALT ? HALT : FETCH;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next  = FETCH;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    retire_s    = 1'b0;
    illegal_s   = 1'b0;
    case (cur)
      FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_update  = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into alu_out for BEQ
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            illegal_s  = 1'b1;
            state_next = fault_next;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src  = RES_MEM;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      EXECR, EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = (cur == EXECR) ? SRCB_RS2 : SRCB_IMM;
        alu_op    = (cur == EXECR) ? ALUOP_R : ALUOP_I;
        if (bad_funct) begin
          // Skip the write-back entirely; the decoder already forces ADD
          illegal_s  = 1'b1;
          state_next = fault_next;
        end else begin
          state_next = ALUWB;
        end
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retire_s  = 1'b1;
      end
      JAL: begin
        // Latch PC+4 into alu_out for rd while the PC takes the target from result
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (alu_ctrl),
    .bad_funct(bad_funct)
  );

  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign mem_write = ~reset & mem_write_s;
  assign ir_write  = ~reset & ir_write_s;
  assign reg_write = ~reset & reg_write_s;
  assign retire    = ~reset & retire_s;
  assign illegal   = ~reset & illegal_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a second instance built with ILLEGAL_HALT=1.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_ctrl;

  logic       clk, reset, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_ctrl;

  logic       pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, retire2, illegal2;
  logic [1:0] result_src2, alu_src_a2, alu_src_b2, imm_src2;
  logic [3:0] alu_ctrl2;

  int checks = 0;
  int fails  = 0;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .retire(retire), .illegal(illegal)
  );

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
    .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .imm_src(imm_src2), .alu_ctrl(alu_ctrl2),
    .retire(retire2), .illegal(illegal2)
  );

  // Observation word: pcw adr memw irw regw rs[2] aA[2] aB[2] alu[4] ret ill
  logic [16:0] obs1, obs2;
  assign obs1 = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_ctrl, retire, illegal};
  assign obs2 = {pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, result_src2,
                 alu_src_a2, alu_src_b2, alu_ctrl2, retire2, illegal2};

  function automatic logic [16:0] ex(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] aa, input logic [1:0] ab,
                                     input logic [3:0] alu, input logic ret, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, aa, ab, alu, ret, ill};
  endfunction

  // Hand-written expected output words per state
  function automatic logic [16:0] e_fetch();  return ex(1,0,0,1,0,2'b10,2'b00,2'b10,4'd0,0,0); endfunction
  function automatic logic [16:0] e_decode(input logic ill);
    return ex(0,0,0,0,0,2'b00,2'b01,2'b01,4'd0,0,ill);
  endfunction
  function automatic logic [16:0] e_memadr(); return ex(0,0,0,0,0,2'b00,2'b10,2'b01,4'd0,0,0); endfunction
  function automatic logic [16:0] e_memrd();  return ex(0,1,0,0,0,2'b00,2'b00,2'b00,4'd0,0,0); endfunction
  function automatic logic [16:0] e_memwb();  return ex(0,0,0,0,1,2'b01,2'b00,2'b00,4'd0,1,0); endfunction
  function automatic logic [16:0] e_memwr();  return ex(0,1,1,0,0,2'b00,2'b00,2'b00,4'd0,1,0); endfunction
  function automatic logic [16:0] e_exec(input logic isr, input logic [3:0] alu, input logic ill);
    return ex(0,0,0,0,0,2'b00,2'b10,isr ? 2'b00 : 2'b01,alu,0,ill);
  endfunction
  function automatic logic [16:0] e_aluwb();  return ex(0,0,0,0,1,2'b00,2'b00,2'b00,4'd0,1,0); endfunction
  function automatic logic [16:0] e_beq(input logic z);
    return ex(z,0,0,0,0,2'b00,2'b10,2'b00,4'd1,1,0);
  endfunction
  function automatic logic [16:0] e_jal();    return ex(1,0,0,0,0,2'b00,2'b01,2'b10,4'd0,0,0); endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_write, ir_write, mem_write, reg_write, retire, illegal} !== 6'b0 || alu_src_b !== 2'b10) begin
        fails++;
        $display("FAIL reset_hold cyc%0d enables=%b srcb=%b, required enables=000000 srcb=10",
                 i, {pc_write, ir_write, mem_write, reg_write, retire, illegal}, alu_src_b);
      end
      step();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== e_fetch()) begin
      fails++;
      $display("FAIL reset_release got %h required %h", obs1, e_fetch());
    end
  endtask

  task automatic test_mem();
    logic [16:0] e [5];
    // lw
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    e[0] = e_fetch(); e[1] = e_decode(0); e[2] = e_memadr(); e[3] = e_memrd(); e[4] = e_memwb();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs1 !== e[i] || imm_src !== 2'b00) begin
        fails++;
        $display("FAIL lw cyc%0d got %h imm %b required %h imm 00", i, obs1, imm_src, e[i]);
      end
      step();
    end
    // sw
    op = 7'b0100011;
    e[0] = e_fetch(); e[1] = e_decode(0); e[2] = e_memadr(); e[3] = e_memwr();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs1 !== e[i] || imm_src !== 2'b01) begin
        fails++;
        $display("FAIL sw cyc%0d got %h imm %b required %h imm 01", i, obs1, imm_src, e[i]);
      end
      step();
    end
  endtask

  task automatic test_alu();
    logic [16:0] e [4];
    logic [6:0]  t_op  [5] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
    logic [2:0]  t_f3  [5] = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b011};
    logic        t_f7  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  t_alu [5] = '{4'd1, 4'd0, 4'd6, 4'd5, 4'd0};
    logic        t_bad [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          n;
    for (int k = 0; k < 5; k++) begin
      op = t_op[k]; funct3 = t_f3[k]; funct7b5 = t_f7[k]; zero = 1'b0;
      e[0] = e_fetch(); e[1] = e_decode(0);
      e[2] = e_exec(t_op[k] == 7'b0110011, t_alu[k], t_bad[k]);
      e[3] = e_aluwb();
      n = t_bad[k] ? 3 : 4;
      for (int i = 0; i < n; i++) begin
        #1;
        checks++;
        if (obs1 !== e[i]) begin
          fails++;
          $display("FAIL alu%0d cyc%0d got %h required %h", k, i, obs1, e[i]);
        end
        step();
      end
    end
    // a bad funct3 must drop straight back to FETCH
    #1;
    checks++;
    if (obs1 !== e_fetch()) begin
      fails++;
      $display("FAIL alu_bad_return got %h required %h", obs1, e_fetch());
    end
  endtask

  task automatic test_beq();
    logic [16:0] e [3];
    for (int z = 1; z >= 0; z--) begin
      op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z[0];
      e[0] = e_fetch(); e[1] = e_decode(0); e[2] = e_beq(z[0]);
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++;
        if (obs1 !== e[i] || imm_src !== 2'b10) begin
          fails++;
          $display("FAIL beq_z%0d cyc%0d got %h imm %b required %h imm 10", z, i, obs1, imm_src, e[i]);
        end
        step();
      end
    end
  endtask

  task automatic test_jal_illegal();
    logic [16:0] e [4];
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    e[0] = e_fetch(); e[1] = e_decode(0); e[2] = e_jal(); e[3] = e_aluwb();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs1 !== e[i] || imm_src !== 2'b11) begin
        fails++;
        $display("FAIL jal cyc%0d got %h imm %b required %h imm 11", i, obs1, imm_src, e[i]);
      end
      step();
    end
    op = 7'b1111111;
    e[0] = e_fetch(); e[1] = e_decode(1); e[2] = e_fetch();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs1 !== e[i]) begin
        fails++;
        $display("FAIL illegal_op cyc%0d got %h required %h", i, obs1, e[i]);
      end
      if (i < 2) step();
    end
  endtask

  task automatic test_halt();
    logic [16:0] e [5];
    reset = 1'b1;
    step();
    reset = 1'b0;
    op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    e[0] = e_fetch(); e[1] = e_decode(1); e[2] = '0; e[3] = '0; e[4] = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs2 !== e[i]) begin
        fails++;
        $display("FAIL halt cyc%0d got %h required %h", i, obs2, e[i]);
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (obs2 !== e_fetch()) begin
      fails++;
      $display("FAIL halt_exit got %h required %h", obs2, e_fetch());
    end
  endtask

  task automatic test_reset_mid();
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    step(); step(); step();
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      fails++;
      $display("FAIL memwrite_reach got %b required 1", mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || retire !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort mw=%b ret=%b irw=%b pcw=%b required all 0",
               mem_write, retire, ir_write, pc_write);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== e_fetch()) begin
      fails++;
      $display("FAIL reset_abort_fetch got %h required %h", obs1, e_fetch());
    end
  endtask

  task automatic test_random_stream();
    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
    int k, exp_cyc, cyc, retires, legal_cnt;
    logic exp_legal, saw_ret, done;
    retires = 0; legal_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      k        = $urandom_range(0, 7);
      op       = ops[k];
      funct3   = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      zero     = 1'($urandom_range(0, 1));
      exp_legal = 1'b1;
      case (k)
        0: exp_cyc = 5;
        1: exp_cyc = 4;
        2, 3: begin
          exp_legal = !(funct3 == 3'b011 || funct3 == 3'b101);
          exp_cyc   = exp_legal ? 4 : 3;
        end
        4: exp_cyc = 3;
        5: exp_cyc = 4;
        default: begin exp_cyc = 2; exp_legal = 1'b0; end
      endcase
      if (exp_legal) legal_cnt++;
      cyc = 0; done = 1'b0; saw_ret = 1'b0;
      while (!done && cyc < 10) begin
        #1;
        if (retire)  begin retires++; saw_ret = 1'b1; end
        if (retire || illegal) done = 1'b1;
        cyc++;
        step();
      end
      checks++;
      if (cyc !== exp_cyc || saw_ret !== exp_legal) begin
        fails++;
        $display("FAIL stream%0d op=%b f3=%b cycles=%0d retired=%b required cycles=%0d retired=%b",
                 n, op, funct3, cyc, saw_ret, exp_cyc, exp_legal);
      end
    end
    checks++;
    if (retires !== legal_cnt) begin
      fails++;
      $display("FAIL stream_retire_count got %0d required %0d", retires, legal_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_alu();
    test_beq();
    test_jal_illegal();
    test_halt();
    test_reset_mid();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1);
  end

endmodule
